// File: rtl/core_pkg.sv
// Shared types and defaults for the fetch front end.
// Holds PC-generator state/source enums and the alignment helper.
package core_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } pc_state_e;

    typedef enum logic [2:0] {
        SEQ,
        BR,
        JALR,
        TRAP,
        MRET
    } pc_src_e;

    // Without compressed support only bit1 matters; with it, bit0.
    function automatic logic addr_misaligned(
        input logic [1:0] lsb,
        input logic       c_ext
    );
        return c_ext ? lsb[0] : lsb[1];
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Redirect target priority mux with alignment check.
// Ports: i_* redirect requests/operands; o_target, o_src, o_misaligned.
module pc_target_sel
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int C_EXT = 0
) (
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_pc,
    input  logic [XLEN-1:0] i_imm_op,
    input  logic            i_jalr_en,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic            i_trap_en,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_mret_en,
    input  logic [XLEN-1:0] i_epc,
    output logic [XLEN-1:0] o_target,
    output pc_src_e         o_src,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_jalr_tgt;

    assign w_br_tgt   = i_br_pc + i_imm_op;
    assign w_jalr_tgt = (i_rs1_val + i_imm_op) & {{(XLEN-1){1'b1}}, 1'b0};

    always_comb begin
        o_target = '0;
        o_src    = SEQ;
        if (i_trap_en) begin
            o_target = i_trap_vec;
            o_src    = TRAP;
        end else if (i_mret_en) begin
            o_target = i_epc;
            o_src    = MRET;
        end else if (i_jalr_en) begin
            o_target = w_jalr_tgt;
            o_src    = JALR;
        end else if (i_br_taken) begin
            o_target = w_br_tgt;
            o_src    = BR;
        end
    end

    // Trap and MRET addresses come from CSRs and are trusted.
    assign o_misaligned = ((o_src == BR) || (o_src == JALR)) &&
                          addr_misaligned(o_target[1:0], C_EXT != 0);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator at the front of fetch.
// Ports: redirect sources in, imem request handshake, pc/pc_plus, misalign report.
module pc_gen
    import core_pkg::*;
#(
    parameter int              XLEN         = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(core_pkg::RESET_VECTOR),
    parameter int              C_EXT        = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] imm_op,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_en,
    input  logic [XLEN-1:0] epc,
    input  logic            is_compressed,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            misaligned_err,
    output logic [XLEN-1:0] misaligned_addr
);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic            r_err;
    logic [XLEN-1:0] r_err_addr;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_target;

    logic [XLEN-1:0] w_target;
    pc_src_e         w_src;
    logic            w_mis;
    logic            w_redir;
    logic            w_adv;
    logic [XLEN-1:0] w_step;

    pc_target_sel #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_sel (
        .i_br_taken   (br_taken),
        .i_br_pc      (br_pc),
        .i_imm_op     (imm_op),
        .i_jalr_en    (jalr_en),
        .i_rs1_val    (rs1_val),
        .i_trap_en    (trap_en),
        .i_trap_vec   (trap_vec),
        .i_mret_en    (mret_en),
        .i_epc        (epc),
        .o_target     (w_target),
        .o_src        (w_src),
        .o_misaligned (w_mis)
    );

    assign w_step  = ((C_EXT != 0) && is_compressed) ? XLEN'(2) : XLEN'(4);
    assign pc_plus = r_pc + w_step;
    assign w_adv   = r_valid & imem_req_ready & ~stall;
    assign w_redir = (w_src != SEQ) & ~w_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_valid       <= 1'b0;
            r_err         <= 1'b0;
            r_err_addr    <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_valid <= 1'b1;
                end
                RUN: begin
                    if (w_mis) begin
                        r_err      <= 1'b1;
                        r_err_addr <= w_target;
                    end else if (w_redir) begin
                        if (w_adv) begin
                            r_pc <= w_target;
                        end else begin
                            r_pend_target <= w_target;
                            r_pend_valid  <= 1'b1;
                            r_state       <= HOLD;
                        end
                    end else if (w_adv) begin
                        r_pc <= pc_plus;
                    end
                end
                HOLD: begin
                    // Only a trap may replace the held redirect; the
                    // rest originate on the wrong path.
                    if (w_adv && r_pend_valid) begin
                        r_pc         <= trap_en ? trap_vec : r_pend_target;
                        r_pend_valid <= 1'b0;
                        r_state      <= RUN;
                    end else if (trap_en) begin
                        r_pend_target <= trap_vec;
                    end
                end
                default: begin
                    r_state <= BOOT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc              = r_pc;
    assign imem_req_valid  = r_valid;
    assign misaligned_err  = r_err;
    assign misaligned_addr = r_err_addr;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen (C_EXT=0, RESET_VECTOR=0).
// One task per scenario; each checks its own expected values.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] imm_op;
    logic        jalr_en;
    logic [31:0] rs1_val;
    logic        trap_en;
    logic [31:0] trap_vec;
    logic        mret_en;
    logic [31:0] epc;
    logic        is_compressed;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        misaligned_err;
    logic [31:0] misaligned_addr;

    int errors = 0;
    int checks = 0;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_taken        (br_taken),
        .br_pc           (br_pc),
        .imm_op          (imm_op),
        .jalr_en         (jalr_en),
        .rs1_val         (rs1_val),
        .trap_en         (trap_en),
        .trap_vec        (trap_vec),
        .mret_en         (mret_en),
        .epc             (epc),
        .is_compressed   (is_compressed),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .pc              (pc),
        .pc_plus         (pc_plus),
        .misaligned_err  (misaligned_err),
        .misaligned_addr (misaligned_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall    = 1'b0;
        br_taken = 1'b0;
        br_pc    = '0;
        imm_op   = '0;
        jalr_en  = 1'b0;
        rs1_val  = '0;
        trap_en  = 1'b0;
        trap_vec = '0;
        mret_en  = 1'b0;
        epc      = '0;
    endtask

    task automatic test_reset();
        clear_in();
        is_compressed  = 1'b0;
        imem_req_ready = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0);
        end
        checks++;
        if (imem_req_valid !== 1'b0 || misaligned_err !== 1'b0 ||
            misaligned_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outs got=%b/%b/%h exp=0/0/0",
                     imem_req_valid, misaligned_err, misaligned_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL boot got valid=%b pc=%h exp valid=0 pc=0",
                     imem_req_valid, pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== 32'(4 * i) || imem_req_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq%0d got pc=%h v=%b exp pc=%h v=1",
                         i, pc, imem_req_valid, 32'(4 * i));
            end
        end
        checks++;
        if (pc_plus !== 32'hC) begin
            errors++;
            $display("FAIL pc_plus got=%h exp=%h", pc_plus, 32'hC);
        end
    endtask

    task automatic test_branch();
        tick();
        br_taken = 1'b1;
        br_pc    = 32'h10;
        imm_op   = 32'hFFFF_FFF8;
        tick();
        clear_in();
        checks++;
        if (pc !== 32'h8) begin
            errors++;
            $display("FAIL branch got=%h exp=%h", pc, 32'h8);
        end
    endtask

    task automatic test_misaligned();
        jalr_en = 1'b1;
        rs1_val = 32'h101;
        imm_op  = 32'h2;
        tick();
        clear_in();
        checks++;
        if (pc !== 32'h8 || misaligned_err !== 1'b1 ||
            misaligned_addr !== 32'h102) begin
            errors++;
            $display("FAIL misalign got pc=%h err=%b addr=%h exp 8/1/102",
                     pc, misaligned_err, misaligned_addr);
        end
        tick();
        checks++;
        if (misaligned_err !== 1'b0 || pc !== 32'hC) begin
            errors++;
            $display("FAIL misalign_pulse got err=%b pc=%h exp 0/c",
                     misaligned_err, pc);
        end
    endtask

    task automatic test_hold();
        stall    = 1'b1;
        br_taken = 1'b1;
        br_pc    = 32'h30;
        imm_op   = 32'h10;
        tick();
        br_taken = 1'b0;
        jalr_en  = 1'b1;
        rs1_val  = 32'h80;
        imm_op   = 32'h0;
        tick();
        checks++;
        if (pc !== 32'hC || imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_stall got pc=%h v=%b exp c/1",
                     pc, imem_req_valid);
        end
        clear_in();
        tick();
        checks++;
        if (pc !== 32'h40) begin
            errors++;
            $display("FAIL hold_release got=%h exp=%h", pc, 32'h40);
        end
        tick();
        checks++;
        if (pc !== 32'h44) begin
            errors++;
            $display("FAIL hold_resume got=%h exp=%h", pc, 32'h44);
        end
    endtask

    task automatic test_trap_in_hold();
        stall    = 1'b1;
        br_taken = 1'b1;
        br_pc    = 32'h30;
        imm_op   = 32'h10;
        tick();
        br_taken = 1'b0;
        trap_en  = 1'b1;
        trap_vec = 32'h200;
        tick();
        clear_in();
        tick();
        checks++;
        if (pc !== 32'h200) begin
            errors++;
            $display("FAIL trap_hold got=%h exp=%h", pc, 32'h200);
        end
    endtask

    task automatic test_ready_low();
        imem_req_ready = 1'b0;
        br_taken = 1'b1;
        br_pc    = 32'h100;
        tick();
        clear_in();
        tick();
        checks++;
        if (pc !== 32'h200) begin
            errors++;
            $display("FAIL ready_low got=%h exp=%h", pc, 32'h200);
        end
        imem_req_ready = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL ready_redir got=%h exp=%h", pc, 32'h100);
        end
    endtask

    task automatic test_priority();
        mret_en = 1'b1;
        epc     = 32'h300;
        jalr_en = 1'b1;
        rs1_val = 32'h500;
        tick();
        checks++;
        if (pc !== 32'h300) begin
            errors++;
            $display("FAIL mret_over_jalr got=%h exp=%h", pc, 32'h300);
        end
        trap_en  = 1'b1;
        trap_vec = 32'h400;
        tick();
        clear_in();
        checks++;
        if (pc !== 32'h400) begin
            errors++;
            $display("FAIL trap_over_mret got=%h exp=%h", pc, 32'h400);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        tick();
        tick();
        checks++;
        if (pc !== 32'h400 || imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall got pc=%h v=%b exp 400/1",
                     pc, imem_req_valid);
        end
        stall = 1'b0;
    endtask

    task automatic test_wrap();
        br_taken = 1'b1;
        br_pc    = 32'hFFFF_FFF0;
        imm_op   = 32'hC;
        tick();
        clear_in();
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pre got pc=%h plus=%h exp fffffffc/0",
                     pc, pc_plus);
        end
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap got=%h exp=%h", pc, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        stall    = 1'b1;
        br_taken = 1'b1;
        br_pc    = 32'h30;
        imm_op   = 32'h10;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got pc=%h v=%b exp 0/0",
                     pc, imem_req_valid);
        end
        clear_in();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h0 || imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_boot got pc=%h v=%b exp 0/1",
                     pc, imem_req_valid);
        end
        tick();
        checks++;
        if (pc !== 32'h4) begin
            errors++;
            $display("FAIL reset_lost got=%h exp=%h", pc, 32'h4);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_misaligned();
        test_hold();
        test_trap_in_hold();
        test_ready_low();
        test_priority();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the pipelined core. It is the successor to the single-cycle PC register and sits at the front of the fetch stage. It selects the next PC from sequential, branch/JAL, JALR, trap and MRET sources, and drives an instruction-memory request handshake. Redirects that arrive while fetch cannot advance are held, and misaligned targets are flagged without redirecting.

Parameters:
XLEN, 32, datapath and address width.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
C_EXT, 0, 1 = compressed support: 2-byte alignment and a sequential step of 2 or 4. 0 = 4-byte alignment and a step of 4.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hazard stall from the decode stage; the PC holds
br_taken  in  1  branch or JAL taken, resolved in EX
br_pc  in  XLEN  PC of the resolving branch/JAL
imm_op  in  XLEN  sign-extended immediate
jalr_en  in  1  JALR resolved in EX
rs1_val  in  XLEN  JALR base register
trap_en  in  1  trap taken
trap_vec  in  XLEN  trap handler address (mtvec)
mret_en  in  1  MRET retired
epc  in  XLEN  return address (mepc)
is_compressed  in  1  current instruction is 16-bit; ignored when C_EXT=0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  instruction memory accepts the request
pc  out  XLEN  current fetch PC
pc_plus  out  XLEN  pc + step
misaligned_err  out  1  one-cycle pulse: misaligned redirect target
misaligned_addr  out  XLEN  the offending target

Behaviour:
- Reset values (async on rst=0):
  - pc = RESET_VECTOR
  - state = BOOT
  - imem_req_valid = 0
  - misaligned_err = 0
  - misaligned_addr = 0
  - pend_valid = 0
- States:
  - BOOT: imem_req_valid = 0; unconditionally moves to RUN on the next edge. The PC stays at RESET_VECTOR.
  - RUN: imem_req_valid = 1.
  - HOLD: a redirect is pending; imem_req_valid = 1, still fetching the old PC.
- Advance condition: adv = imem_req_valid & imem_req_ready & ~stall.
- Step size: step = 2 if (C_EXT & is_compressed), else 4. pc_plus = pc + step, combinational.
- Targets, all arithmetic modulo 2^XLEN, with silent wrap-around:
  - branch target = br_pc + imm_op
  - JALR target = (rs1_val + imm_op) & ~1
  - trap target = trap_vec
  - MRET target = epc
- Priority: trap > mret > jalr > br_taken > sequential.
- Alignment check: a target is misaligned if bit1 ≠ 0 when C_EXT=0, or bit0 ≠ 0 when C_EXT=1. trap_vec and epc are never checked.
- Misaligned target:
  - No redirect occurs; the PC holds.
  - Next cycle: misaligned_err = 1 and misaligned_addr = target.
  - Exactly a 1-cycle pulse.
- Valid redirect in RUN:
  - adv=1: pc <= target on the next edge; stay in RUN.
  - adv=0: latch pend_target and go to HOLD.
- HOLD:
  - New trap_en: overwrites pend_target.
  - Other redirects: ignored, since they come from wrong-path instructions.
  - On adv: pc <= pend_target, pend_valid <= 0, go to RUN.
- Sequential case: when adv=1 with no redirect and no pending redirect, pc <= pc_plus.
- Simultaneous events: a redirect in the same cycle as adv is taken immediately; the sequential step is discarded.
- Stall with no redirect: the PC holds. imem_req_valid remains 1, so the same address is re-requested.
- Reset mid-operation: immediate return to the reset values. Any pending redirect is lost.
- Latency: a redirect is visible on pc one edge after it is asserted, provided adv=1.

Decomposition:
- Shared package core_pkg: XLEN, RESET_VECTOR, the pc_state_e enum (BOOT, RUN, HOLD), and the pc_src_e enum (SEQ, BR, JALR, TRAP, MRET).
- One natural sub-module, pc_target_sel: combinational priority mux plus alignment check. It outputs the target, src and misaligned flag.

Test Plan:
- Reset then release with imem_req_ready=1, stall=0:
  - cycle 0: pc=0, valid=0
  - cycles 1–3: pc = 0, 4, 8 with valid=1
- br_taken=1, br_pc=0x10, imm_op=0xFFFF_FFF8 (with adv=1) → next pc = 0x08.
- jalr_en=1, rs1_val=0x101, imm_op=0x2 with C_EXT=0:
  - target 0x102 is misaligned
  - pc holds; next cycle misaligned_err=1 for one cycle, misaligned_addr=0x102
- stall=1 while br_taken=1 (target 0x40), then jalr_en=1 (target 0x80):
  - state = HOLD; the JALR is ignored
  - on stall release, pc = 0x40
- HOLD with pend_target 0x40, then trap_en=1 with trap_vec=0x200 → pc = 0x200 after adv.
- Wrap-around: pc=0xFFFF_FFFC with sequential advance → pc = 0x0000_0000.
